// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a big-endian byte stream into
// 32-bit words, writes them to consecutive addresses, and holds the CPU in reset.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  imem_loader_if.slave    bus,
  output logic            cpu_reset,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic count_ok;
  logic last_word;
  logic byte_hs;

  assign count_ok  = (word_count != '0) && (word_count <= CNT_W'(DEPTH_WORDS));
  // Widened compare so a full-depth load never needs index DEPTH_WORDS.
  assign last_word = ((CNT_W'(idx_q) + CNT_W'(1)) == cnt_q);
  assign byte_hs   = bus.in_valid && in_ready_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          if (count_ok) begin
            state_d    = ST_RECV;
            idx_d      = '0;
            bcnt_d     = '0;
            cnt_d      = word_count;
            error_d    = 1'b0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_RECV: begin
        in_ready_d = 1'b1;
        if (byte_hs) begin
          word_d = {word_q[23:0], bus.in_data};
          bcnt_d = bcnt_q + 2'(1);
          if (bcnt_q == 2'd3) begin
            state_d     = ST_WRITE;
            in_ready_d  = 1'b0;
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q;
            mem_wdata_d = {word_q[23:0], bus.in_data};
          end
        end
      end
      ST_WRITE: begin
        if (last_word) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          state_d    = ST_RECV;
          idx_d      = idx_q + ADDR_W'(1);
          in_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: start-acceptance table plus hand-written
// load sequences, with a write logger checking addresses, data and pulse widths.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [ADDR_W:0] word_count = '0;
  logic            cpu_reset, busy, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (bus.slave),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Write logger, sampled mid-cycle.
  int          n_wr = 0;
  logic [5:0]  wa [0:255];
  logic [31:0] wd [0:255];
  int          we_long = 0;
  int          rdy_bad = 0;
  logic        we_prev = 1'b0;

  always @(negedge clock) begin
    if (bus.mem_we) begin
      if (n_wr < 256) begin
        wa[n_wr] = bus.mem_addr;
        wd[n_wr] = bus.mem_wdata;
      end
      n_wr = n_wr + 1;
    end
    if (bus.mem_we && we_prev) we_long = we_long + 1;
    if (busy && !bus.mem_we && !bus.in_ready) rdy_bad = rdy_bad + 1;
    we_prev = bus.mem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, ".mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, ".mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, ".mem_wdata"}, bus.mem_wdata,      32'd0);
    check({tag, ".cpu_reset"}, 32'(cpu_reset),     32'd1);
    check({tag, ".busy"},      32'(busy),          32'd0);
    check({tag, ".done"},      32'(done),          32'd0);
    check({tag, ".error"},     32'(error),         32'd0);
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  // Holds a byte valid until accepted, then idles for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic hs;
    bit   ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      hs = bus.in_ready;
      tick();
      if (hs) ok = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_byte timeout: byte 0x%02h never accepted", b);
    end
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    check({name, ".done_reached"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [ADDR_W:0] wc;
    logic            exp_error;
    logic            exp_busy;
    logic            exp_ready;
  } start_vec_t;

  logic [7:0]  stream [0:7];
  start_vec_t  vecs [0:5];
  int          base;

  initial begin
    vecs[0] = '{wc: 7'd0,   exp_error: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[1] = '{wc: 7'd65,  exp_error: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[2] = '{wc: 7'd127, exp_error: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[3] = '{wc: 7'd1,   exp_error: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
    vecs[4] = '{wc: 7'd64,  exp_error: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
    vecs[5] = '{wc: 7'd33,  exp_error: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
    stream[0] = 8'h20; stream[1] = 8'h08; stream[2] = 8'h00; stream[3] = 8'h05;
    stream[4] = 8'h8C; stream[5] = 8'h09; stream[6] = 8'h00; stream[7] = 8'h04;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Start acceptance table, each from a fresh reset.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = n_wr;
      pulse_start(vecs[v].wc);
      check($sformatf("tbl%0d.error", v),     32'(error),        32'(vecs[v].exp_error));
      check($sformatf("tbl%0d.busy", v),      32'(busy),         32'(vecs[v].exp_busy));
      check($sformatf("tbl%0d.in_ready", v),  32'(bus.in_ready), 32'(vecs[v].exp_ready));
      check($sformatf("tbl%0d.cpu_reset", v), 32'(cpu_reset),    32'd1);
      tick();
      check($sformatf("tbl%0d.no_write", v),  32'(n_wr - base),  32'd0);
    end

    // Two-word back-to-back load.
    do_reset();
    check_reset_vals("rst");
    base = n_wr;
    pulse_start(7'd2);
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.cpu_reset", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    check("b2b.we_last", 32'(bus.mem_we), 32'd1);
    check("b2b.done_early", 32'(done), 32'd0);
    tick();
    check("b2b.done", 32'(done), 32'd1);
    check("b2b.cpu_reset_low", 32'(cpu_reset), 32'd0);
    check("b2b.busy_low", 32'(busy), 32'd0);
    check("b2b.n_wr", 32'(n_wr - base), 32'd2);
    check("b2b.addr0", 32'(wa[base]), 32'd0);
    check("b2b.data0", wd[base], 32'h20080005);
    check("b2b.addr1", 32'(wa[base+1]), 32'd1);
    check("b2b.data1", wd[base+1], 32'h8C090004);

    // Same stream with gaps between bytes; starts directly from DONE.
    base = n_wr;
    pulse_start(7'd2);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 3);
    wait_done("gap");
    check("gap.n_wr", 32'(n_wr - base), 32'd2);
    check("gap.addr0", 32'(wa[base]), 32'd0);
    check("gap.data0", wd[base], 32'h20080005);
    check("gap.addr1", 32'(wa[base+1]), 32'd1);
    check("gap.data1", wd[base+1], 32'h8C090004);

    // Rejected starts, then a valid start clears error.
    do_reset();
    base = n_wr;
    pulse_start(7'd0);
    check("err0.error", 32'(error), 32'd1);
    check("err0.cpu_reset", 32'(cpu_reset), 32'd1);
    check("err0.busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    check("err0.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    pulse_start(7'd65);
    check("err65.error", 32'(error), 32'd1);
    check("err65.busy", 32'(busy), 32'd0);
    check("err.no_write", 32'(n_wr - base), 32'd0);
    pulse_start(7'd1);
    check("err.cleared", 32'(error), 32'd0);
    check("err.busy", 32'(busy), 32'd1);

    // Full-depth load, word i equals i.
    do_reset();
    base = n_wr;
    pulse_start(7'd64);
    for (int w = 0; w < 64; w++) begin
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'(w), 0);
    end
    wait_done("full");
    check("full.n_wr", 32'(n_wr - base), 32'd64);
    for (int w = 0; w < 64; w++) begin
      check($sformatf("full.addr%0d", w), 32'(wa[base+w]), 32'(w));
      check($sformatf("full.data%0d", w), wd[base+w], 32'(w));
    end

    // Reset mid-load after two words and two bytes.
    do_reset();
    base = n_wr;
    pulse_start(7'd3);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");
    tick();
    tick();
    check("midrst.n_wr", 32'(n_wr - base), 32'd2);
    base = n_wr;
    pulse_start(7'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    wait_done("midrst");
    check("midrst.n_wr2", 32'(n_wr - base), 32'd1);
    check("midrst.addr", 32'(wa[base]), 32'd0);
    check("midrst.data", wd[base], 32'hAABBCCDD);

    // Start in RECV is ignored.
    do_reset();
    base = n_wr;
    pulse_start(7'd2);
    send_byte(stream[0], 0);
    send_byte(stream[1], 0);
    pulse_start(7'd1);
    check("recvstart.busy", 32'(busy), 32'd1);
    for (int i = 2; i < 8; i++) send_byte(stream[i], 0);
    wait_done("recvstart");
    check("recvstart.n_wr", 32'(n_wr - base), 32'd2);
    check("recvstart.data0", wd[base], 32'h20080005);
    check("recvstart.data1", wd[base+1], 32'h8C090004);

    // Start in DONE restarts at address 0.
    base = n_wr;
    pulse_start(7'd1);
    check("donestart.cpu_reset", 32'(cpu_reset), 32'd1);
    check("donestart.busy", 32'(busy), 32'd1);
    check("donestart.done", 32'(done), 32'd0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    wait_done("donestart");
    check("donestart.n_wr", 32'(n_wr - base), 32'd1);
    check("donestart.addr", 32'(wa[base]), 32'd0);
    check("donestart.data", wd[base], 32'h11223344);

    // Rejected start from DONE returns to IDLE holding the CPU.
    pulse_start(7'd0);
    check("donerej.error", 32'(error), 32'd1);
    check("donerej.cpu_reset", 32'(cpu_reset), 32'd1);
    check("donerej.done", 32'(done), 32'd0);

    // Reset and start in the same cycle: reset wins.
    reset = 1'b1;
    start = 1'b1;
    word_count = 7'd1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rststart.busy", 32'(busy), 32'd0);
    check("rststart.error", 32'(error), 32'd0);

    check("we_single_cycle", 32'(we_long), 32'd0);
    check("ready_steady", 32'(rdy_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
